instr_prefetcher: RTL



---
 rtl/instr_prefetcher_pkg.sv | 9 +
 rtl/instr_prefetcher_if.sv | 30 +++
 rtl/instr_prefetcher_fifo.sv | 54 +++++
 rtl/instr_prefetcher.sv | 92 +++++++++
 4 files changed

// File: rtl/instr_prefetcher_pkg.sv
// Shared defaults for the instruction prefetch stage: memory widths, buffer depth, reset PC.
package instr_prefetcher_pkg;

  localparam int IMEM_ADDR_WIDTH = 16;
  localparam int IMEM_DATA_WIDTH = 16;
  localparam int PF_DEPTH        = 4;
  localparam logic [IMEM_ADDR_WIDTH-1:0] PF_RESET_PC = '0;

endpackage

// File: rtl/instr_prefetcher_if.sv
// Bus bundle of the prefetcher: fetch handshake to instruction memory, valid/ready to the CPU, redirect.
interface instr_prefetcher_if
  import instr_prefetcher_pkg::*;
#(
  parameter int ADDR_WIDTH = IMEM_ADDR_WIDTH,
  parameter int DATA_WIDTH = IMEM_DATA_WIDTH
);

  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_ack;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  instr_valid;
  logic                  instr_ready;
  logic [DATA_WIDTH-1:0] instr;
  logic [ADDR_WIDTH-1:0] instr_pc;
  logic                  redirect;
  logic [ADDR_WIDTH-1:0] redirect_pc;

  modport master (
    output mem_req, mem_addr, instr_valid, instr, instr_pc,
    input  mem_ack, mem_rdata, instr_ready, redirect, redirect_pc
  );

  modport slave (
    input  mem_req, mem_addr, instr_valid, instr, instr_pc,
    output mem_ack, mem_rdata, instr_ready, redirect, redirect_pc
  );

endinterface

// File: rtl/instr_prefetcher_fifo.sv
// Synchronous FIFO holding {pc, word} entries; flush empties it in one cycle.
module prefetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     nreset,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o,
  output logic                     full_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push, do_pop;

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_push = push_i & (~full_o | pop_i);
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));

endmodule

// File: rtl/instr_prefetcher.sv
// Sequential instruction prefetcher: credit-limited fetch requests, {pc,word} buffer, redirect flush.
module instr_prefetcher
  import instr_prefetcher_pkg::*;
#(
  parameter int ADDR_WIDTH = IMEM_ADDR_WIDTH,
  parameter int DATA_WIDTH = IMEM_DATA_WIDTH,
  parameter int DEPTH      = PF_DEPTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(PF_RESET_PC)
) (
  input logic                clock,
  input logic                nreset,
  instr_prefetcher_if.master bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                             req_q, req_d;
  logic [ADDR_WIDTH-1:0]            addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]            fetch_pc_q, fetch_pc_d;
  logic                             discard_q, discard_d;
  logic                             ack, push, pop, room, issue;
  logic [CNT_W-1:0]                 count, count_after;
  logic                             empty, full;
  logic [ADDR_WIDTH+DATA_WIDTH-1:0] head;

  assign ack  = bus.mem_ack & req_q;
  assign push = ack & ~discard_q & ~bus.redirect;
  assign pop  = ~empty & bus.instr_ready & ~bus.redirect;

  // Only one request is in flight, so a new one may go out once the current one completes
  // and the buffer still has a free slot to reserve for its response.
  assign count_after = count + CNT_W'(push) - CNT_W'(pop);
  assign room        = full ? pop : (count_after < CNT_W'(DEPTH));
  assign issue       = (~req_q | ack) & ~bus.redirect & room;

  always_comb begin
    req_d      = req_q;
    addr_d     = addr_q;
    fetch_pc_d = fetch_pc_q;
    discard_d  = discard_q;
    if (ack) req_d = 1'b0;
    if (issue) begin
      req_d      = 1'b1;
      addr_d     = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(1);
    end
    // An unacked request cannot be withdrawn; its response is marked for dropping instead.
    if (bus.redirect) begin
      fetch_pc_d = bus.redirect_pc;
      discard_d  = req_q & ~bus.mem_ack;
    end else if (ack) begin
      discard_d  = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      req_q      <= 1'b0;
      addr_q     <= RESET_PC;
      fetch_pc_q <= RESET_PC;
      discard_q  <= 1'b0;
    end else begin
      req_q      <= req_d;
      addr_q     <= addr_d;
      fetch_pc_q <= fetch_pc_d;
      discard_q  <= discard_d;
    end
  end

  prefetch_fifo #(
    .WIDTH (ADDR_WIDTH + DATA_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .nreset  (nreset),
    .flush_i (bus.redirect),
    .push_i  (push),
    .data_i  ({addr_q, bus.mem_rdata}),
    .pop_i   (pop),
    .data_o  (head),
    .count_o (count),
    .empty_o (empty),
    .full_o  (full)
  );

  assign bus.mem_req     = req_q;
  assign bus.mem_addr    = addr_q;
  assign bus.instr_valid = ~empty;
  assign bus.instr       = empty ? '0 : head[DATA_WIDTH-1:0];
  assign bus.instr_pc    = empty ? '0 : head[ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH];

endmodule
